memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Load/store stage directly downstream of the ALU in the RockWave core.
- Takes the ALU result (aluout) as an effective address or a pass-through result, plus store data and funct3.
- Performs byte/half/word data-bus accesses with a request/acknowledge handshake, lane alignment, sign/zero extension, misalignment detection and bus timeout.
- Emits a single-cycle result pulse to writeback.

Parameters:
- TIMEOUT, 16: bus cycles to wait for bus_ack before aborting; 0 = wait forever.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents an operation.
- ex_ready  out  1  stage can accept an operation.
- aluout  in  32  ALU result: address for load/store, result otherwise.
- store_data  in  32  rs2 value for stores.
- funct3  in  3  RV32I load/store width code.
- is_load  in  1  operation is a load.
- is_store  in  1  operation is a store; wins if is_load is also set.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address; bits [1:0] are always 0.
- bus_wstrb  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_ack  in  1  bus completes the access this cycle.
- bus_rdata  in  32  read data, valid with bus_ack.
- wb_valid  out  1  one-cycle result pulse.
- wb_data  out  32  result value.
- fault  out  1  misaligned or illegal funct3; valid with wb_valid.
- bus_err  out  1  timeout abort; valid with wb_valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0; all outputs 0 except ex_ready=1. Reset during REQ drops bus_req immediately and discards the operation.
- States are IDLE and REQ. ex_ready=1 only in IDLE. Acceptance = ex_valid & ex_ready at a rising edge.
- Accepted, neither load nor store: next cycle wb_valid=1, wb_data=aluout, fault=0, bus_err=0. State stays IDLE (1 op/cycle).
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
- Accepted load/store with illegal funct3 or misaligned address: next cycle wb_valid=1, fault=1, wb_data=0. No bus access; stay IDLE.
- Accepted legal, aligned access: next cycle state=REQ and bus_req=1.
  - bus_addr={aluout[31:2],2'b00}; bus_we=is_store.
  - Loads: bus_wstrb=0000, bus_wdata=0.
  - SB: wstrb=0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: wstrb=0011<<addr[1:0], wdata={2{store_data[15:0]}}.
  - SW: wstrb=1111, wdata=store_data.
  - All bus outputs are held stable until termination.
- REQ, bus_ack=1 on a rising edge:
  - Next cycle bus_req=0 (bus outputs cleared), state=IDLE, wb_valid=1.
  - Store: wb_data=0.
  - Load: byte lane = bus_rdata >> (8*addr[1:0]); half = addr[1] ? rdata[31:16] : rdata[15:0].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW takes rdata unchanged.
  - Minimum load/store latency is acceptance + 2 cycles to wb_valid when ack arrives in the first REQ cycle.
- bus_ack in IDLE is ignored. bus_ack is first sampled on the first edge with bus_req=1.
- Timeout (TIMEOUT>0): counter clears on entry to REQ and increments on each REQ edge without ack.
  - At counter==TIMEOUT-1 with no ack: next cycle bus_req=0, state=IDLE, wb_valid=1, bus_err=1, wb_data=0.
  - Ack on that same edge wins: normal completion, bus_err=0.
- wb_valid is a pulse with no backpressure; wb_data/fault/bus_err return to 0 when wb_valid=0.

Test Plan:
- Pass-through: aluout=0x0000_0011, is_load=is_store=0, funct3=000 -> wb_valid pulse next cycle, wb_data=0x0000_0011, no bus_req. Back-to-back ops give wb_valid on consecutive cycles.
- Load sign/zero: LB then LBU at addr 0x0000_0103, bus_rdata=0x80FF_1234, ack in first REQ cycle -> bus_addr=0x0000_0100. LB gives wb_data=0xFFFF_FF80; LBU gives 0x0000_0080, 2 cycles after acceptance.
- Store lanes: SH addr 0x0000_0202, store_data=0xDEAD_BEEF -> bus_we=1, wstrb=1100, wdata=0xBEEF_BEEF, held through 3 wait cycles until ack; then wb_valid, wb_data=0.
- Misalign/illegal: LW addr 0x0000_0006 -> fault=1, no bus_req. Store with funct3=100 -> fault=1.
- Timeout: TIMEOUT=4, LW with bus_ack stuck 0 -> bus_req high exactly 4 cycles, then wb_valid with bus_err=1. A repeat with ack on the 4th cycle gives normal completion with bus_err=0.
- Reset mid-access: rst_n=0 while in REQ -> bus_req drops asynchronously, no wb_valid. After release, ex_ready=1 and a new LW completes correctly.

Source files
------------

// File: rtl/memory_access.sv
// rtl/memory_access.sv - load/store stage with bus handshake, lane alignment, extension and timeout
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   ex_valid/ex_ready  operation handshake from execute; ready only in IDLE
//   aluout             effective address for loads/stores, result otherwise
//   store_data         rs2 value for stores
//   funct3             RV32I load/store width code
//   is_load/is_store   operation kind; store wins when both are set
//   bus_*              word-addressed data bus with req/ack handshake
//   wb_valid/wb_data   single-cycle result pulse to writeback
//   fault              misaligned access or illegal funct3 (with wb_valid)
//   bus_err            bus timeout abort (with wb_valid)

module memory_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] aluout,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Unused when TIMEOUT==0; the cast keeps the expression legal either way.
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic          st_q;

    // Decode of the operation presented by execute
    logic accept, op_st, op_ld, op_mem, legal, aligned;
    logic go, flt, pass, tmo_hit;

    assign ex_ready = (state_q == IDLE);
    assign accept   = ex_valid & ex_ready;
    assign op_st    = is_store;
    assign op_ld    = is_load & ~is_store;
    assign op_mem   = op_st | op_ld;

    always_comb begin
        legal = 1'b0;
        if (op_st) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else if (op_ld) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes width for both loads and stores
    always_comb begin
        aligned = 1'b1;
        case (funct3[1:0])
            2'b01:   aligned = ~aluout[0];
            2'b10:   aligned = (aluout[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    assign go   = accept & op_mem & legal & aligned;
    assign flt  = accept & op_mem & ~(legal & aligned);
    assign pass = accept & ~op_mem;

    // Ack on the final count edge wins over the timeout
    assign tmo_hit = (TIMEOUT > 0) && (state_q == REQ) && (cnt_q == TMAX) && !bus_ack;

    // Load result extraction from the captured lane and width
    logic [31:0] shifted;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_val;

    assign shifted = bus_rdata >> {lane_q, 3'b000};
    assign rbyte   = shifted[7:0];
    assign rhalf   = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        load_val = 32'd0;
        case (f3_q)
            3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b010:  load_val = bus_rdata;
            3'b100:  load_val = {24'd0, rbyte};
            3'b101:  load_val = {16'd0, rhalf};
            default: load_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = REQ;
            REQ:     if (bus_ack || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wstrb <= 4'd0;
            bus_wdata <= 32'd0;
            wb_valid  <= 1'b0;
            wb_data   <= 32'd0;
            fault     <= 1'b0;
            bus_err   <= 1'b0;
            cnt_q     <= '0;
            f3_q      <= 3'd0;
            lane_q    <= 2'd0;
            st_q      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_data  <= 32'd0;
            fault    <= 1'b0;
            bus_err  <= 1'b0;
            if (state_q == IDLE) begin
                if (pass) begin
                    wb_valid <= 1'b1;
                    wb_data  <= aluout;
                end else if (flt) begin
                    wb_valid <= 1'b1;
                    fault    <= 1'b1;
                end else if (go) begin
                    bus_req  <= 1'b1;
                    bus_we   <= op_st;
                    bus_addr <= {aluout[31:2], 2'b00};
                    f3_q     <= funct3;
                    lane_q   <= aluout[1:0];
                    st_q     <= op_st;
                    cnt_q    <= '0;
                    if (op_st) begin
                        case (funct3[1:0])
                            2'b00: begin
                                bus_wstrb <= 4'b0001 << aluout[1:0];
                                bus_wdata <= {4{store_data[7:0]}};
                            end
                            2'b01: begin
                                bus_wstrb <= 4'b0011 << aluout[1:0];
                                bus_wdata <= {2{store_data[15:0]}};
                            end
                            default: begin
                                bus_wstrb <= 4'b1111;
                                bus_wdata <= store_data;
                            end
                        endcase
                    end else begin
                        bus_wstrb <= 4'd0;
                        bus_wdata <= 32'd0;
                    end
                end
            end else begin
                if (bus_ack || tmo_hit) begin
                    bus_req   <= 1'b0;
                    bus_we    <= 1'b0;
                    bus_addr  <= 32'd0;
                    bus_wstrb <= 4'd0;
                    bus_wdata <= 32'd0;
                    wb_valid  <= 1'b1;
                    if (bus_ack) begin
                        wb_data <= st_q ? 32'd0 : load_val;
                    end else begin
                        bus_err <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] aluout;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        fault;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .aluout(aluout), .store_data(store_data), .funct3(funct3),
        .is_load(is_load), .is_store(is_store),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .fault(fault), .bus_err(bus_err)
    );

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd);
        ex_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        aluout     = addr;
        store_data = sd;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        funct3   = 3'd0;
        aluout   = 32'd0;
        store_data = 32'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ex_ready, bus_req, bus_we, wb_valid, fault, bus_err} !== 6'b100000 ||
            bus_addr !== 32'd0 || bus_wstrb !== 4'd0 || bus_wdata !== 32'd0 || wb_data !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready=%b req=%b wbv=%b addr=%h expected ready=1 others 0",
                     ex_ready, bus_req, wb_valid, bus_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        issue(1'b0, 1'b0, 3'b000, 32'h0000_0011, 32'd0);
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0011 || fault !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL pass: wbv=%b data=%h fault=%b req=%b expected 1 00000011 0 0",
                     wb_valid, wb_data, fault, bus_req);
        end
        aluout = 32'h0000_0022;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0022) begin
            errors++;
            $display("FAIL back_to_back: wbv=%b data=%h expected 1 00000022", wb_valid, wb_data);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 32'd0) begin
            errors++;
            $display("FAIL pass_pulse: wbv=%b data=%h expected 0 00000000", wb_valid, wb_data);
        end
    endtask

    // Load with ack in the first REQ cycle: result 2 edges after acceptance
    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp);
        issue(1'b1, 1'b0, f3, addr, 32'd0);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== exp_addr ||
            bus_wstrb !== 4'd0 || bus_wdata !== 32'd0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_bus: req=%b we=%b addr=%h strb=%b ready=%b expected 1 0 %h 0000 0",
                     name, bus_req, bus_we, bus_addr, bus_wstrb, ex_ready, exp_addr);
        end
        bus_ack = 1'b1;
        bus_rdata = rdata;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== exp || bus_req !== 1'b0 || fault !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL %s_data: wbv=%b data=%h req=%b err=%b expected 1 %h 0 0",
                     name, wb_valid, wb_data, bus_req, bus_err, exp);
        end
        bus_rdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_load_ext();
        do_load("lb",  3'b000, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0100, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0100, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_0102, 32'h80FF_1234, 32'h0000_0100, 32'hFFFF_80FF);
        do_load("lhu", 3'b101, 32'h0000_0100, 32'h80FF_9234, 32'h0000_0100, 32'h0000_9234);
    endtask

    task automatic test_store_lanes();
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            checks++;
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h0000_0200 ||
                bus_wstrb !== 4'b1100 || bus_wdata !== 32'hBEEF_BEEF || wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL sh_hold%0d: req=%b we=%b addr=%h strb=%b wdata=%h expected 1 1 00000200 1100 beefbeef",
                         i, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata);
            end
        end
        bus_ack = 1'b1;  // ack on the last count edge must beat the timeout
        @(negedge clk);
        bus_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'd0 || bus_err !== 1'b0 || bus_req !== 1'b0 || bus_wstrb !== 4'd0) begin
            errors++;
            $display("FAIL sh_done: wbv=%b data=%h err=%b req=%b expected 1 0 0 0",
                     wb_valid, wb_data, bus_err, bus_req);
        end
        @(negedge clk);
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus_wstrb !== 4'b0010 || bus_wdata !== 32'hABAB_ABAB || bus_addr !== 32'h0000_0300) begin
            errors++;
            $display("FAIL sb_lane: strb=%b wdata=%h addr=%h expected 0010 abababab 00000300",
                     bus_wstrb, bus_wdata, bus_addr);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fault();
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (wb_valid !== 1'b1 || fault !== 1'b1 || wb_data !== 32'd0 || bus_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL lw_misalign: wbv=%b fault=%b data=%h req=%b expected 1 1 0 0",
                     wb_valid, fault, wb_data, bus_req);
        end
        issue(1'b0, 1'b1, 3'b100, 32'h0000_0008, 32'h1234_5678);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (wb_valid !== 1'b1 || fault !== 1'b1 || wb_data !== 32'd0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL st_illegal: wbv=%b fault=%b data=%h req=%b expected 1 1 0 0",
                     wb_valid, fault, wb_data, bus_req);
        end
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_pulse: wbv=%b fault=%b expected 0 0", wb_valid, fault);
        end
    endtask

    task automatic test_timeout();
        int high_cnt;
        logic seen;
        high_cnt = 0;
        seen = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 12 && !seen; i++) begin
            if (bus_req === 1'b1) begin
                high_cnt++;
            end else begin
                seen = 1'b1;
                checks++;
                if (wb_valid !== 1'b1 || bus_err !== 1'b1 || wb_data !== 32'd0 || fault !== 1'b0) begin
                    errors++;
                    $display("FAIL tmo_result: wbv=%b err=%b data=%h expected 1 1 0",
                             wb_valid, bus_err, wb_data);
                end
            end
            if (!seen) @(negedge clk);
        end
        checks++;
        if (!seen || high_cnt != 4) begin
            errors++;
            $display("FAIL tmo_len: req cycles=%0d ended=%b expected 4 1", high_cnt, seen);
        end
        @(negedge clk);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || bus_err !== 1'b0 || wb_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL tmo_ack_wins: wbv=%b err=%b data=%h expected 1 0 cafef00d",
                     wb_valid, bus_err, wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic saw_wb;
        saw_wb = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: req=%b ready=%b expected 0 1", bus_req, ex_ready);
        end
        bus_ack = 1'b1;
        repeat (2) @(negedge clk) if (wb_valid === 1'b1) saw_wb = 1'b1;
        bus_ack = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk) if (wb_valid === 1'b1) saw_wb = 1'b1;
        checks++;
        if (saw_wb !== 1'b0 || ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_discard: wb seen=%b ready=%b expected 0 1", saw_wb, ex_ready);
        end
        do_load("lw_after_rst", 3'b010, 32'h0000_0020, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_ext();
        test_store_lanes();
        test_fault();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
